umi_req_arbiter: RTL and testbench

Round-robin arbiter that shares one UMI request channel (e.g. the input of a width-converting UMI FIFO feeding a memory agent) between N UMI requesters. Grants are message-atomic: once a requester wins, it keeps the channel until a beat with EOM set is accepted downstream. A stalled beat never has its grant changed. The datapath is a zero-latency combinational mux. Sequential state covers the priority pointer, the message lock and the stall hold.

---
 rtl/umi_req_arbiter.sv | 135 +++++++++++++
 tb/tb_umi_req_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter sharing one UMI request channel among N requesters.
// Grants are message-atomic and never move while a beat is stalled; the datapath is a pure mux.
module umi_req_arbiter #(
  parameter int N  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    grant,
  output logic            locked
);

  // Handshake: a beat moves when umi_out_valid & umi_out_ready; only the granted
  // requester sees ready, and a requester must hold its beat until that happens.

  localparam int PW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          hold_q, hold_d;

  logic [N-1:0]  cand;
  logic [PW-1:0] pick;
  logic          pick_vld;
  logic [PW-1:0] g;
  logic          g_vld;
  logic          accept;
  logic          eom;
  int            idx;

  // Fresh round-robin pick: first unmasked valid requester scanning from ptr.
  always_comb begin
    cand     = umi_in_valid & ~mask;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick     = PW'(idx);
      end
    end
  end

  // A message lock or a stalled beat pins the grant to owner.
  always_comb begin
    g     = pick;
    g_vld = pick_vld;
    if (state_q == LOCKED || hold_q) begin
      g     = owner_q;
      g_vld = 1'b1;
    end
    if (reset) begin
      g     = '0;
      g_vld = 1'b0;
    end
  end

  assign umi_out_cmd     = umi_in_cmd[int'(g)*CW +: CW];
  assign umi_out_dstaddr = umi_in_dstaddr[int'(g)*AW +: AW];
  assign umi_out_srcaddr = umi_in_srcaddr[int'(g)*AW +: AW];
  assign umi_out_data    = umi_in_data[int'(g)*DW +: DW];
  assign umi_out_valid   = g_vld & umi_in_valid[g];

  always_comb begin
    grant        = '0;
    umi_in_ready = '0;
    if (g_vld) begin
      grant[g]        = 1'b1;
      umi_in_ready[g] = umi_out_ready;
    end
  end

  assign accept = umi_out_valid & umi_out_ready;
  assign eom    = umi_out_cmd[22];
  assign locked = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (accept) begin
      hold_d = 1'b0;
      if (eom) begin
        state_d = IDLE;
        ptr_d   = (int'(g) == N - 1) ? '0 : g + PW'(1);
      end else begin
        state_d = LOCKED;
        owner_d = g;
      end
    end else if (umi_out_valid && state_q == IDLE) begin
      owner_d = g;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Bench for umi_req_arbiter: directed scenarios plus random traffic against a
// claim-based reference model; a second N=2 instance checks strict alternation.
module tb_umi_req_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int OW = N + 1 + N + 1 + CW + 2 * AW + DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic [N-1:0]    in_valid, in_ready, mask, grant;
  logic [CW-1:0]   r_cmd[N];
  logic [AW-1:0]   r_dst[N], r_src[N];
  logic [DW-1:0]   r_data[N];
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst, in_src;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready, locked;
  logic [CW-1:0]   out_cmd;
  logic [AW-1:0]   out_dst, out_src;
  logic [DW-1:0]   out_data;
  logic [OW-1:0]   obs, exp_v;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign in_cmd[i*CW +: CW]  = r_cmd[i];
    assign in_dst[i*AW +: AW]  = r_dst[i];
    assign in_src[i*AW +: AW]  = r_src[i];
    assign in_data[i*DW +: DW] = r_data[i];
  end

  assign obs = {grant, out_valid, in_ready, locked, out_cmd, out_dst, out_src, out_data};

  umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready),
    .mask(mask), .grant(grant), .locked(locked)
  );

  // ---------------- N=2 instance ----------------
  logic [1:0]      v2, rdy2, mask2, grant2;
  logic [CW-1:0]   r2_cmd[2];
  logic [DW-1:0]   r2_data[2];
  logic [2*AW-1:0] dst2, src2;
  logic            out_valid2, out_ready2, locked2;
  logic [CW-1:0]   out_cmd2;
  logic [AW-1:0]   out_dst2, out_src2;
  logic [DW-1:0]   out_data2;

  umi_req_arbiter #(.N(2), .CW(CW), .AW(AW), .DW(DW)) dut2 (
    .clk(clk), .reset(reset),
    .umi_in_valid(v2), .umi_in_cmd({r2_cmd[1], r2_cmd[0]}), .umi_in_dstaddr(dst2),
    .umi_in_srcaddr(src2), .umi_in_data({r2_data[1], r2_data[0]}), .umi_in_ready(rdy2),
    .umi_out_valid(out_valid2), .umi_out_cmd(out_cmd2), .umi_out_dstaddr(out_dst2),
    .umi_out_srcaddr(out_src2), .umi_out_data(out_data2), .umi_out_ready(out_ready2),
    .mask(mask2), .grant(grant2), .locked(locked2)
  );

  int compared = 0;
  int failed   = 0;

  // ---------------- reference model ----------------
  // m_owner is the requester holding a claim on the channel (stalled beat or
  // open message), -1 when the next beat is up for round-robin arbitration.
  int m_ptr;
  int m_owner;
  bit m_locked;

  function automatic int m_pick();
    int i;
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (in_valid[i] && !mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] m_expect();
    int g;
    int s;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic ev;
    g  = reset ? -1 : m_pick();
    eg = '0;
    er = '0;
    ev = 1'b0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ev    = in_valid[g];
      er[g] = out_ready;
    end
    s = (g < 0) ? 0 : g;
    return {eg, ev, er, (reset ? 1'b0 : m_locked), r_cmd[s], r_dst[s], r_src[s], r_data[s]};
  endfunction

  task automatic m_commit();
    int g;
    if (reset) begin
      m_ptr    = 0;
      m_owner  = -1;
      m_locked = 1'b0;
      return;
    end
    g = m_pick();
    if (g >= 0 && in_valid[g]) begin
      if (out_ready) begin
        if (r_cmd[g][22]) begin
          m_ptr    = (g + 1) % N;
          m_owner  = -1;
          m_locked = 1'b0;
        end else begin
          m_owner  = g;
          m_locked = 1'b1;
        end
      end else begin
        m_owner = g;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input bit v, input bit e);
    in_valid[i]  = v;
    r_cmd[i]     = $urandom;
    r_cmd[i][22] = e;
    r_dst[i]     = {$urandom, $urandom};
    r_src[i]     = {$urandom, $urandom};
    r_data[i]    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    mask = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 1'b1, 1'b1);
    v2 = '0; mask2 = '0; out_ready2 = 1'b0; dst2 = '0; src2 = '0;
    r2_cmd[0] = '0; r2_cmd[1] = '0; r2_data[0] = '0; r2_data[1] = '0;
    m_commit();
    #3;
    exp_v = m_expect();
    compared++;
    if (obs !== exp_v) begin
      failed++;
      $display("FAIL reset_outputs: got %h need %h", obs, exp_v);
    end
    compared++;
    if ({grant, out_valid, in_ready} !== '0) begin
      failed++;
      $display("FAIL reset_zero: got grant=%b valid=%b ready=%b need 0", grant, out_valid, in_ready);
    end
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      for (int i = 0; i < N; i++) load(i, 1'b1, 1'b1);
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL rotation_model c%0d: got %h need %h", c, obs, exp_v);
      end
      compared++;
      if (grant !== N'(1 << (c % N))) begin
        failed++;
        $display("FAIL rotation_grant c%0d: got %b need %b", c, grant, N'(1 << (c % N)));
      end
      m_commit();
    end
  endtask

  task automatic test_multibeat();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      load(0, 1'b1, 1'b1);
      load(2, 1'b1, 1'b1);
      load(3, 1'b0, 1'b0);
      load(1, c < 3, c == 2);
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL multibeat_model c%0d: got %h need %h", c, obs, exp_v);
      end
      if (c < 3) begin
        compared++;
        if (grant !== 4'b0010) begin
          failed++;
          $display("FAIL multibeat_grant c%0d: got %b need 0010", c, grant);
        end
      end
      if (c == 1) begin
        compared++;
        if (locked !== 1'b1) begin
          failed++;
          $display("FAIL multibeat_locked: got %b need 1", locked);
        end
      end
      if (c == 3) begin
        compared++;
        if ({grant, locked} !== 5'b0100_0) begin
          failed++;
          $display("FAIL multibeat_release: got grant=%b locked=%b need 0100/0", grant, locked);
        end
      end
      m_commit();
    end
  endtask

  task automatic test_stall();
    next_cycle();
    for (int i = 0; i < N; i++) load(i, 1'b0, 1'b1);
    load(2, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      out_ready = (c >= 4);
      if (c == 1) load(0, 1'b1, 1'b1);
      if (c == 5) in_valid[2] = 1'b0;
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL stall_model c%0d: got %h need %h", c, obs, exp_v);
      end
      compared++;
      if (grant !== ((c <= 4) ? 4'b0100 : 4'b0001)) begin
        failed++;
        $display("FAIL stall_grant c%0d: got %b need %b", c, grant, (c <= 4) ? 4'b0100 : 4'b0001);
      end
      m_commit();
    end
  endtask

  task automatic test_mask();
    mask = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) load(i, 1'b1, 1'b1);
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL mask_model c%0d: got %h need %h", c, obs, exp_v);
      end
      compared++;
      if (grant[1] !== 1'b0) begin
        failed++;
        $display("FAIL mask_excluded c%0d: got grant=%b need bit1=0", c, grant);
      end
      m_commit();
    end
    // req1 opens a message unmasked, then gets masked mid-message
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      mask = (c == 0) ? 4'b0000 : 4'b0010;
      for (int i = 0; i < N; i++) load(i, c > 0, 1'b1);
      load(1, c < 4, c == 3);
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL mask_lock_model c%0d: got %h need %h", c, obs, exp_v);
      end
      compared++;
      if ((c < 4) ? (grant !== 4'b0010) : (grant[1] !== 1'b0)) begin
        failed++;
        $display("FAIL mask_lock_grant c%0d: got %b need %s", c, grant, (c < 4) ? "0010" : "bit1=0");
      end
      m_commit();
    end
    mask = '0;
  endtask

  task automatic test_reset_mid_message();
    next_cycle();
    for (int i = 0; i < N; i++) load(i, 1'b0, 1'b1);
    load(3, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    exp_v = m_expect();
    compared++;
    if (obs !== exp_v) begin
      failed++;
      $display("FAIL rstmid_open: got %h need %h", obs, exp_v);
    end
    m_commit();
    next_cycle();
    for (int i = 0; i < N; i++) load(i, 1'b1, 1'b1);
    load(3, 1'b1, 1'b0);
    #2;
    compared++;
    if ({grant, out_valid, locked} !== 6'b1000_1_1) begin
      failed++;
      $display("FAIL rstmid_locked: got grant=%b valid=%b locked=%b need 1000/1/1", grant, out_valid, locked);
    end
    reset = 1'b1;
    #1;
    m_commit();
    exp_v = m_expect();
    compared++;
    if (obs !== exp_v) begin
      failed++;
      $display("FAIL rstmid_async: got %h need %h", obs, exp_v);
    end
    next_cycle();
    reset = 1'b0;
    load(0, 1'b0, 1'b1);
    @(negedge clk);
    exp_v = m_expect();
    compared++;
    if ({grant, locked} !== 5'b0010_0 || obs !== exp_v) begin
      failed++;
      $display("FAIL rstmid_restart: got %h need %h", obs, exp_v);
    end
    m_commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) load(i, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      exp_v = m_expect();
      compared++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL random c%0d: got %h need %h", c, obs, exp_v);
      end
      m_commit();
    end
  endtask

  task automatic test_n2_alternation();
    logic [1:0] exp_q[$];
    logic [1:0] eg;
    int s;
    for (int c = 0; c < 6; c++) exp_q.push_back((c % 2 == 0) ? 2'b01 : 2'b10);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      v2 = 2'b11;
      out_ready2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
        r2_cmd[i]     = $urandom;
        r2_cmd[i][22] = 1'b1;
        r2_data[i]    = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      eg = exp_q.pop_front();
      s  = eg[1] ? 1 : 0;
      compared++;
      if ({grant2, rdy2, out_valid2, locked2} !== {eg, eg, 1'b1, 1'b0} || out_data2 !== r2_data[s]) begin
        failed++;
        $display("FAIL n2_alternation c%0d: got grant=%b ready=%b data=%h need grant=%b data=%h",
                 c, grant2, rdy2, out_data2, eg, r2_data[s]);
      end
    end
    v2 = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_multibeat();
    test_stall();
    test_mask();
    test_reset_mid_message();
    test_random();
    test_n2_alternation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
